// File: rtl/ddr_timing_monitor.sv
// rtl/ddr_timing_monitor.sv - DDR4 command-bus timing monitor with coded, registered violation events
module ddr_timing_monitor #(
    parameter int NUM_BG    = 4,
    parameter int BG_W      = $clog2(NUM_BG),
    parameter int CNT_W     = 14,
    parameter int ERR_W     = 16,
    parameter int tRCD      = 11,
    parameter int tRP       = 11,
    parameter int tRAS      = 28,
    parameter int tRRD      = 4,
    parameter int tCCD_S    = 4,
    parameter int tCCD_L    = 6,
    parameter int tWR2RD    = 18,
    parameter int tMRD      = 8,
    parameter int tMOD      = 24,
    parameter int tRFC      = 208,
    parameter int tREFI_MAX = 6240
) (
    input  logic              clock_t,
    input  logic              reset,
    input  logic              cke,
    input  logic              cs_n,
    input  logic              act_n,
    input  logic              ras_n_a16,
    input  logic              cas_n_a15,
    input  logic              we_n_a14,
    input  logic [BG_W-1:0]   bg_addr,
    input  logic [1:0]        ba_addr,
    input  logic              addr_a10,
    input  logic              check_en,
    output logic              viol_valid,
    output logic [3:0]        viol_code,
    output logic [BG_W+1:0]   viol_bank,
    output logic [12:0]       err_flags,
    output logic [ERR_W-1:0]  err_count
);
    localparam int NB   = NUM_BG * 4;
    localparam int BK_W = BG_W + 2;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX  = '1;
    localparam cnt_t CNT_ONE  = cnt_t'(1);
    localparam cnt_t T_RCD    = cnt_t'(tRCD);
    localparam cnt_t T_RP     = cnt_t'(tRP);
    localparam cnt_t T_RAS    = cnt_t'(tRAS);
    localparam cnt_t T_RRD    = cnt_t'(tRRD);
    localparam cnt_t T_CCD_S  = cnt_t'(tCCD_S);
    localparam cnt_t T_CCD_L  = cnt_t'(tCCD_L);
    localparam cnt_t T_WR2RD  = cnt_t'(tWR2RD);
    localparam cnt_t T_MRD    = cnt_t'(tMRD);
    localparam cnt_t T_MOD    = cnt_t'(tMOD);
    localparam cnt_t T_RFC    = cnt_t'(tRFC);
    localparam cnt_t T_LATE   = cnt_t'(tREFI_MAX + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    // Distance counters: value is the number of edges since the last event
    cnt_t bank_act_cnt [NB];
    cnt_t bank_pre_cnt [NB];
    cnt_t bg_cas_cnt   [NUM_BG];
    cnt_t act_cnt, cas_cnt, wr_cnt, mrs_cnt, ref_cnt;

    logic [NB-1:0]   bank_open;
    logic            ref_armed;
    logic [BK_W-1:0] bank;

    logic live, is_act, is_mrs, is_ref, is_pre, is_rd, is_wr, is_zq, is_cas, is_cmd;
    logic ras_hit, ref_late, cmd_any;
    logic [12:0] cmd_mask;
    logic [12:0] hit_mask;
    logic [3:0]  first_code;

    assign bank = {bg_addr, ba_addr};

    function automatic cnt_t sat_inc(input cnt_t c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    // Decode the command pins into command strobes (NOP and reserved encodings decode to nothing)
    always_comb begin
        live   = cke && !cs_n;
        is_act = live && !act_n;
        is_mrs = 1'b0;
        is_ref = 1'b0;
        is_pre = 1'b0;
        is_rd  = 1'b0;
        is_wr  = 1'b0;
        is_zq  = 1'b0;
        if (live && act_n) begin
            case ({ras_n_a16, cas_n_a15, we_n_a14})
                3'b000:  is_mrs = 1'b1;
                3'b001:  is_ref = 1'b1;
                3'b010:  is_pre = 1'b1;
                3'b101:  is_rd  = 1'b1;
                3'b100:  is_wr  = 1'b1;
                3'b110:  is_zq  = 1'b1;
                default: ;
            endcase
        end
        is_cas = is_rd || is_wr;
        is_cmd = is_act || is_mrs || is_ref || is_pre || is_cas || is_zq;
    end

    // tRAS applies to every bank a PRE closes, so scan all targeted open banks
    always_comb begin
        ras_hit = 1'b0;
        for (int i = 0; i < NB; i++) begin
            if ((addr_a10 || BK_W'(i) == bank) && bank_open[i] && bank_act_cnt[i] < T_RAS)
                ras_hit = 1'b1;
        end
    end

    // Evaluate every check against pre-update counter values; bit i-1 holds code i
    always_comb begin
        cmd_mask     = '0;
        cmd_mask[0]  = is_cas && bank_act_cnt[bank] < T_RCD;
        cmd_mask[1]  = is_act && bank_pre_cnt[bank] < T_RP;
        cmd_mask[2]  = is_pre && ras_hit;
        cmd_mask[3]  = is_act && act_cnt < T_RRD;
        cmd_mask[4]  = is_cas && cas_cnt < T_CCD_S;
        cmd_mask[5]  = is_cas && bg_cas_cnt[bg_addr] < T_CCD_L;
        cmd_mask[6]  = is_rd && wr_cnt < T_WR2RD;
        cmd_mask[7]  = is_mrs && mrs_cnt < T_MRD;
        cmd_mask[8]  = is_cmd && !is_mrs && mrs_cnt < T_MOD;
        cmd_mask[9]  = is_cmd && ref_cnt < T_RFC;
        cmd_mask[11] = is_cas && !bank_open[bank];
        cmd_mask[12] = is_act && bank_open[bank];
        ref_late     = ref_armed && ref_cnt == T_LATE;
        cmd_any      = |cmd_mask;
        hit_mask     = cmd_mask | {2'b00, ref_late, 10'b0};
    end

    // Lowest command code wins; with no command violation only REF_LATE can be pending
    always_comb begin
        first_code = 4'd11;
        for (int i = 12; i >= 0; i--) begin
            if (cmd_mask[i]) first_code = 4'(i + 1);
        end
    end

    // Per-bank ACT/PRE distance counters (PRE-all reloads every bank's PRE counter)
    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NB; i++) begin
                bank_act_cnt[i] <= CNT_MAX;
                bank_pre_cnt[i] <= CNT_MAX;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                bank_act_cnt[i] <= (is_act && bank == BK_W'(i)) ? CNT_ONE : sat_inc(bank_act_cnt[i]);
                bank_pre_cnt[i] <= (is_pre && (addr_a10 || bank == BK_W'(i))) ? CNT_ONE
                                                                               : sat_inc(bank_pre_cnt[i]);
            end
        end
    end

    // Per-group CAS and global distance counters
    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < NUM_BG; g++) bg_cas_cnt[g] <= CNT_MAX;
            act_cnt <= CNT_MAX;
            cas_cnt <= CNT_MAX;
            wr_cnt  <= CNT_MAX;
            mrs_cnt <= CNT_MAX;
            ref_cnt <= CNT_MAX;
        end else begin
            for (int g = 0; g < NUM_BG; g++)
                bg_cas_cnt[g] <= (is_cas && bg_addr == BG_W'(g)) ? CNT_ONE : sat_inc(bg_cas_cnt[g]);
            act_cnt <= is_act ? CNT_ONE : sat_inc(act_cnt);
            cas_cnt <= is_cas ? CNT_ONE : sat_inc(cas_cnt);
            wr_cnt  <= is_wr  ? CNT_ONE : sat_inc(wr_cnt);
            mrs_cnt <= is_mrs ? CNT_ONE : sat_inc(mrs_cnt);
            ref_cnt <= is_ref ? CNT_ONE : sat_inc(ref_cnt);
        end
    end

    // Bank open/idle tracking and the refresh-deadline arm (one report per missed deadline)
    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            bank_open <= '0;
            ref_armed <= 1'b0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (is_act && bank == BK_W'(i))
                    bank_open[i] <= 1'b1;
                else if (is_pre && (addr_a10 || bank == BK_W'(i)))
                    bank_open[i] <= 1'b0;
            end
            if (is_ref)
                ref_armed <= 1'b1;
            else if (ref_late)
                ref_armed <= 1'b0;
        end
    end

    // Registered violation pulse, sticky flags and saturating error count
    always_ff @(posedge clock_t or posedge reset) begin
        if (reset) begin
            viol_valid <= 1'b0;
            viol_code  <= '0;
            viol_bank  <= '0;
            err_flags  <= '0;
            err_count  <= '0;
        end else begin
            viol_valid <= 1'b0;
            viol_code  <= '0;
            viol_bank  <= '0;
            if (check_en && (cmd_any || ref_late)) begin
                viol_valid <= 1'b1;
                viol_code  <= first_code;
                viol_bank  <= cmd_any ? bank : '0;
                err_flags  <= err_flags | hit_mask;
                if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ddr_timing_monitor.sv
// tb/tb_ddr_timing_monitor.sv - self-checking bench for ddr_timing_monitor
`timescale 1ns/1ps
module tb_ddr_timing_monitor;
    localparam int NUM_BG  = 4;
    localparam int BG_W    = 2;
    localparam int NB      = 16;
    localparam int ERR_W   = 5;
    localparam int ERR_MAX = 31;
    localparam int T_RCD = 11, T_RP = 11, T_RAS = 28, T_RRD = 4, T_CCD_S = 4, T_CCD_L = 6;
    localparam int T_WR2RD = 18, T_MRD = 8, T_MOD = 24, T_RFC = 208, T_REFI_MAX = 6240;
    localparam int NEVER = -1000000;
    localparam int K_DES = 0, K_NOP = 1, K_ACT = 2, K_MRS = 3, K_REF = 4;
    localparam int K_PRE = 5, K_RD = 6, K_WR = 7, K_ZQ = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cke = 1'b1, cs_n = 1'b1, act_n = 1'b1, ras = 1'b1, cas = 1'b1, we = 1'b1;
    logic [BG_W-1:0] bg = '0;
    logic [1:0] ba = '0;
    logic a10 = 1'b0, check_en = 1'b1;
    logic viol_valid;
    logic [3:0] viol_code;
    logic [BG_W+1:0] viol_bank;
    logic [12:0] err_flags;
    logic [ERR_W-1:0] err_count;

    always #5 clk = ~clk;

    ddr_timing_monitor #(.NUM_BG(NUM_BG), .ERR_W(ERR_W)) dut (
        .clock_t(clk), .reset(reset), .cke(cke), .cs_n(cs_n), .act_n(act_n),
        .ras_n_a16(ras), .cas_n_a15(cas), .we_n_a14(we), .bg_addr(bg), .ba_addr(ba),
        .addr_a10(a10), .check_en(check_en), .viol_valid(viol_valid), .viol_code(viol_code),
        .viol_bank(viol_bank), .err_flags(err_flags), .err_count(err_count)
    );

    // Model: timestamps of the last events, in sampling-edge numbers
    int now;
    int last_act_b [NB];
    int last_pre_b [NB];
    int last_cas_g [NUM_BG];
    int last_act, last_cas, last_wr, last_mrs, last_ref;
    bit ref_seen;
    bit open_b [NB];
    logic exp_valid;
    logic [3:0] exp_code;
    logic [3:0] exp_bank;
    logic [12:0] exp_flags;
    int exp_count;

    int n_checks = 0;
    int n_fail = 0;
    bit started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, now);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            last_act_b[i] = NEVER;
            last_pre_b[i] = NEVER;
            open_b[i] = 0;
        end
        for (int g = 0; g < NUM_BG; g++) last_cas_g[g] = NEVER;
        last_act = NEVER; last_cas = NEVER; last_wr = NEVER; last_mrs = NEVER; last_ref = NEVER;
        ref_seen = 0;
        exp_valid = 0; exp_code = 0; exp_bank = 0; exp_flags = 0; exp_count = 0;
    endtask

    task automatic model_eval();
        bit live, act, mrs, refc, pre, rd, wr, zq, casc, nondes, late;
        int b, g, code;
        logic [12:0] m;
        live = cke && !cs_n;
        act = live && !act_n;
        mrs = 0; refc = 0; pre = 0; rd = 0; wr = 0; zq = 0;
        if (live && act_n) begin
            case ({ras, cas, we})
                3'b000: mrs = 1;
                3'b001: refc = 1;
                3'b010: pre = 1;
                3'b101: rd = 1;
                3'b100: wr = 1;
                3'b110: zq = 1;
                default: ;
            endcase
        end
        casc = rd || wr;
        nondes = act || mrs || refc || pre || casc || zq;
        g = int'(bg);
        b = g * 4 + int'(ba);
        m = '0;
        if (casc && now - last_act_b[b] < T_RCD) m[0] = 1;
        if (act && now - last_pre_b[b] < T_RP) m[1] = 1;
        if (pre)
            for (int i = 0; i < NB; i++)
                if ((a10 || i == b) && open_b[i] && now - last_act_b[i] < T_RAS) m[2] = 1;
        if (act && now - last_act < T_RRD) m[3] = 1;
        if (casc && now - last_cas < T_CCD_S) m[4] = 1;
        if (casc && now - last_cas_g[g] < T_CCD_L) m[5] = 1;
        if (rd && now - last_wr < T_WR2RD) m[6] = 1;
        if (mrs && now - last_mrs < T_MRD) m[7] = 1;
        if (nondes && !mrs && now - last_mrs < T_MOD) m[8] = 1;
        if (nondes && now - last_ref < T_RFC) m[9] = 1;
        if (casc && !open_b[b]) m[11] = 1;
        if (act && open_b[b]) m[12] = 1;
        late = ref_seen && (now - last_ref == T_REFI_MAX + 1);
        exp_valid = 0; exp_code = 0; exp_bank = 0;
        if (check_en && (m != 0 || late)) begin
            code = 11;
            for (int c = 13; c >= 1; c--) if (c != 11 && m[c-1]) code = c;
            exp_valid = 1;
            exp_code = 4'(code);
            exp_bank = (m != 0) ? 4'(b) : 4'd0;
            exp_flags = exp_flags | m;
            if (late) exp_flags[10] = 1;
            if (exp_count < ERR_MAX) exp_count++;
        end
        if (act) begin last_act_b[b] = now; last_act = now; open_b[b] = 1; end
        if (pre)
            for (int i = 0; i < NB; i++)
                if (a10 || i == b) begin last_pre_b[i] = now; open_b[i] = 0; end
        if (casc) begin last_cas_g[g] = now; last_cas = now; end
        if (wr) last_wr = now;
        if (mrs) last_mrs = now;
        if (refc) begin last_ref = now; ref_seen = 1; end
        now++;
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("viol_valid", 32'(viol_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("viol_code", 32'(viol_code), 32'(exp_code));
                chk("viol_bank", 32'(viol_bank), 32'(exp_bank));
            end
            chk("err_flags", 32'(err_flags), 32'(exp_flags));
            chk("err_count", 32'(err_count), 32'(exp_count));
        end
    end

    task automatic drive(input int k, input int g, input int b, input bit all);
        cs_n = (k == K_DES);
        act_n = (k != K_ACT);
        case (k)
            K_MRS:   {ras, cas, we} = 3'b000;
            K_REF:   {ras, cas, we} = 3'b001;
            K_PRE:   {ras, cas, we} = 3'b010;
            K_RD:    {ras, cas, we} = 3'b101;
            K_WR:    {ras, cas, we} = 3'b100;
            K_ZQ:    {ras, cas, we} = 3'b110;
            default: {ras, cas, we} = 3'b111;
        endcase
        bg = 2'(g);
        ba = 2'(b);
        a10 = all;
    endtask

    task automatic cmd(input int k, input int g = 0, input int b = 0, input bit all = 0);
        drive(k, g, b, all);
        @(posedge clk);
        model_eval();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cmd(K_DES);
    endtask

    task automatic do_reset();
        #1;
        reset = 1;
        check_en = 1;
        drive(K_DES, 0, 0, 0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        now = 0;
        model_clear();
        #1;
        chk("rst_valid", 32'(viol_valid), 0);
        chk("rst_code", 32'(viol_code), 0);
        chk("rst_bank", 32'(viol_bank), 0);
        chk("rst_flags", 32'(err_flags), 0);
        chk("rst_count", 32'(err_count), 0);
        @(negedge clk);
        reset = 0;
        started = 1;

        // tRCD: RD 10 edges after ACT violates, 11 is legal
        cmd(K_ACT, 0, 0); idle(9); cmd(K_RD, 0, 0);
        chk("trcd_valid", 32'(viol_valid), 1);
        chk("trcd_code", 32'(viol_code), 1);
        chk("trcd_bank", 32'(viol_bank), 0);
        chk("trcd_count", 32'(err_count), 1);
        chk("trcd_flags", 32'(err_flags), 13'h001);
        do_reset();
        cmd(K_ACT, 0, 0); idle(10); cmd(K_RD, 0, 0);
        chk("trcd_edge_clean", 32'(viol_valid), 0);

        // tCCD_L / tCCD_S
        do_reset();
        cmd(K_ACT, 0, 0); idle(3); cmd(K_ACT, 1, 0); idle(3); cmd(K_ACT, 0, 1); idle(11);
        cmd(K_RD, 0, 0); idle(4);
        cmd(K_RD, 0, 1);
        chk("ccdl_code", 32'(viol_code), 6);
        chk("ccdl_bank", 32'(viol_bank), 1);
        idle(3); cmd(K_RD, 1, 0);
        chk("ccds_edge_clean", 32'(viol_valid), 0);
        idle(2); cmd(K_RD, 0, 0);
        chk("ccds_code", 32'(viol_code), 5);

        // tMRD / tMOD
        do_reset();
        cmd(K_MRS); idle(6); cmd(K_MRS);
        chk("tmrd_code", 32'(viol_code), 8);
        idle(22); cmd(K_ZQ);
        chk("tmod_code", 32'(viol_code), 9);
        cmd(K_ZQ);
        chk("tmod_edge_clean", 32'(viol_valid), 0);

        // Idle bank, open bank + tRRD, PRE-all then early ACT, early PRE
        do_reset();
        cmd(K_RD, 0, 0);
        chk("casidle_code", 32'(viol_code), 12);
        cmd(K_ACT, 0, 1); cmd(K_DES); cmd(K_ACT, 0, 1);
        chk("actopen_code", 32'(viol_code), 4);
        chk("actopen_flags", 32'(err_flags), 13'h1808);
        idle(27); cmd(K_PRE, 0, 0, 1);
        chk("tras_edge_clean", 32'(viol_valid), 0);
        idle(9); cmd(K_ACT, 0, 0);
        chk("trp_code", 32'(viol_code), 2);
        cmd(K_PRE, 0, 0);
        chk("tras_code", 32'(viol_code), 3);

        // Reset in the middle of a violating command
        do_reset();
        cmd(K_ACT, 0, 0);
        drive(K_RD, 0, 0, 0);
        @(posedge clk);
        model_eval();
        #1;
        chk("mid_pre_valid", 32'(viol_valid), 1);
        reset = 1;
        model_clear();
        #1;
        chk("mid_valid", 32'(viol_valid), 0);
        chk("mid_code", 32'(viol_code), 0);
        chk("mid_flags", 32'(err_flags), 0);
        chk("mid_count", 32'(err_count), 0);
        @(negedge clk); @(posedge clk); @(negedge clk);
        reset = 0;
        cmd(K_RD, 0, 0);
        chk("mid_after_code", 32'(viol_code), 12);

        // check_en=0 suppresses reporting but state tracking continues
        do_reset();
        check_en = 0;
        cmd(K_RD, 0, 0); cmd(K_ACT, 0, 0); cmd(K_ACT, 0, 0);
        chk("dis_valid", 32'(viol_valid), 0);
        chk("dis_count", 32'(err_count), 0);
        check_en = 1;
        idle(9); cmd(K_RD, 0, 0);
        chk("dis_after_code", 32'(viol_code), 1);
        idle(7); cmd(K_WR, 0, 0); idle(9); cmd(K_RD, 0, 0);
        chk("wr2rd_code", 32'(viol_code), 7);

        // Error count saturation with back-to-back violations
        do_reset();
        for (int i = 0; i < 40; i++) cmd(K_RD, 0, 0);
        chk("sat_count", 32'(err_count), ERR_MAX);
        chk("sat_code", 32'(viol_code), 5);

        // Refresh watchdog: silent without REF, one pulse per missed deadline
        do_reset();
        idle(6300);
        chk("noref_count", 32'(err_count), 0);
        cmd(K_REF); idle(6240); cmd(K_DES);
        chk("late_valid", 32'(viol_valid), 1);
        chk("late_code", 32'(viol_code), 11);
        chk("late_flags", 32'(err_flags), 13'h400);
        idle(50);
        chk("late_once", 32'(err_count), 1);
        cmd(K_REF); idle(6240); cmd(K_RD, 0, 0);
        chk("late_cmd_code", 32'(viol_code), 12);
        chk("late_cmd_flags", 32'(err_flags), 13'hC00);
        chk("late_cmd_count", 32'(err_count), 2);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
